// File: rtl/icache_if.sv
// Datapath/cache fetch port and cache/memory instruction port, bundled.
interface icache_if;
    // Datapath side
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    // Memory controller side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // Performance counters
    logic [31:0] hitcount;
    logic [31:0] misscount;

    // Cache view
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, hitcount, misscount
    );

    // Datapath + memory controller view
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hitcount, misscount
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-line instruction cache with hit/miss counters.
module icache #(
    parameter int unsigned NSETS = 16,
    parameter int unsigned IDXW  = 4
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  i_cif
);

    localparam int unsigned TAGW = 30 - IDXW;

    typedef enum logic {StCompare, StFetch} state_e;

    state_e              r_state, w_state_next;
    logic [NSETS-1:0]    r_valid;
    logic [TAGW-1:0]     r_tag  [NSETS];
    logic [31:0]         r_data [NSETS];
    logic [29:0]         r_missaddr, w_missaddr_next;  // word address of the pending fill
    logic [31:0]         r_hitcount, r_misscount;

    logic [IDXW-1:0]     w_idx, w_missidx;
    logic [TAGW-1:0]     w_tag, w_misstag;
    logic                w_hit, w_fill;
    logic                w_unused;

    // Byte offset is ignored: every fetch is treated as word aligned
    assign w_unused  = ^i_cif.imemaddr[1:0];

    assign w_idx     = i_cif.imemaddr[IDXW+1:2];
    assign w_tag     = i_cif.imemaddr[31:IDXW+2];
    assign w_missidx = r_missaddr[IDXW-1:0];
    assign w_misstag = r_missaddr[29:IDXW];

    assign w_hit = (r_state == StCompare) && i_cif.imemREN && r_valid[w_idx]
                   && (r_tag[w_idx] == w_tag);

    assign i_cif.hitcount  = r_hitcount;
    assign i_cif.misscount = r_misscount;

    // Next-state and output decode
    always_comb begin
        w_state_next    = r_state;
        w_missaddr_next = r_missaddr;
        w_fill          = 1'b0;
        i_cif.ihit      = 1'b0;
        i_cif.imemload  = 32'h0;
        i_cif.iREN      = 1'b0;
        i_cif.iaddr     = 32'h0;
        unique case (r_state)
            StCompare: begin
                if (w_hit) begin
                    i_cif.ihit     = 1'b1;
                    i_cif.imemload = r_data[w_idx];
                end else if (i_cif.imemREN) begin
                    w_missaddr_next = i_cif.imemaddr[31:2];
                    w_state_next    = StFetch;
                end
            end
            StFetch: begin
                // Fill always completes with the latched address, even if the request moved
                i_cif.iREN  = 1'b1;
                i_cif.iaddr = {r_missaddr, 2'b00};
                if (!i_cif.iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = StCompare;
                end
            end
            default: w_state_next = StCompare;
        endcase
    end

    // FSM state, miss address and counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= StCompare;
            r_missaddr  <= '0;
            r_hitcount  <= '0;
            r_misscount <= '0;
        end else begin
            r_state    <= w_state_next;
            r_missaddr <= w_missaddr_next;
            if (w_hit)  r_hitcount  <= r_hitcount + 32'd1;
            if (w_fill) r_misscount <= r_misscount + 32'd1;
        end
    end

    // Line valid bits; reset invalidates the whole cache
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_missidx] <= 1'b1;
        end
    end

    // Tag and data arrays, written only on fill completion (no reset needed behind valid)
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_missidx]  <= w_misstag;
            r_data[w_missidx] <= i_cif.iload;
        end
    end

endmodule
